// File: rtl/stream_arbiter.sv
// Round-robin burst arbiter: shares one valid/ready sink among NUM_INPUTS
// requesters, holding each grant until the requester's last beat or the
// MAX_BURST beat cap, with one idle bubble between grants.
module stream_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int INDEX_BITS = 2,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_BITS = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS-1:0]            in_last,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  output logic                             out_last,
  output logic [INDEX_BITS-1:0]            out_source,
  input  logic                             out_ready
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                  state;
  logic [INDEX_BITS-1:0]   grant;
  logic [INDEX_BITS-1:0]   last_grant;
  logic [BURST_BITS-1:0]   beat_count;

  logic [INDEX_BITS-1:0]   winner;
  logic                    found;
  logic                    cap;
  logic                    beat;
  logic [DATA_WIDTH-1:0]   slices [NUM_INPUTS];

  // Split the flat data bus into one slice per requester for indexed selection.
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_slice
    assign slices[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Rotating priority search: scan from the farthest candidate back to the
  // nearest so the last hit is the first valid requester after last_grant.
  always_comb begin
    logic [INDEX_BITS-1:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int off = NUM_INPUTS; off >= 1; off--) begin
      idx = INDEX_BITS'((int'(last_grant) + off) % NUM_INPUTS);
      if (in_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Stream outputs pass straight through from the granted requester.
  always_comb begin
    in_ready   = '0;
    out_data   = '0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_source = '0;
    cap        = &beat_count;
    if (state == GRANT) begin
      out_valid       = in_valid[grant];
      out_data        = out_valid ? slices[grant] : '0;
      in_ready[grant] = out_ready;
      out_source      = grant;
      out_last        = out_valid && (in_last[grant] || cap);
    end
    beat = out_valid && out_ready;
  end

  // Grant state machine: arbitrate in IDLE, count beats and release in GRANT.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= INDEX_BITS'(NUM_INPUTS - 1);
      beat_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant      <= winner;
            state      <= GRANT;
            beat_count <= '0;
          end
        end
        GRANT: begin
          if (beat) begin
            if (out_last) begin
              state      <= IDLE;
              last_grant <= grant;
              beat_count <= '0;
            end else begin
              beat_count <= beat_count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// Directed bench for stream_arbiter with a 4-beat burst cap (BURST_BITS=2).
module tb_stream_arbiter;

  logic        clock;
  logic        reset;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_source;
  logic        out_ready;

  int checks;
  int failures;

  stream_arbiter #(
    .NUM_INPUTS(4),
    .INDEX_BITS(2),
    .DATA_WIDTH(8),
    .BURST_BITS(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_last(out_last),
    .out_source(out_source),
    .out_ready(out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_ready"}, 32'(in_ready), 32'h0);
    chk({tag, "_src"}, 32'(out_source), 32'h0);
    chk({tag, "_data"}, 32'(out_data), 32'h0);
  endtask

  task automatic chk_beat(input string tag, input logic [1:0] src, input logic [7:0] data,
                          input logic last);
    chk({tag, "_src"}, 32'(out_source), 32'(src));
    chk({tag, "_valid"}, 32'(out_valid), 32'h1);
    chk({tag, "_data"}, 32'(out_data), 32'(data));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
    $display("beat %s src=%0d data=%02h last=%0b", tag, out_source, out_data, out_last);
  endtask

  initial begin
    logic [1:0] order [6];
    logic [3:0] mask;
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    order     = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset state
    in_valid = 4'b1111;
    #2;
    chk_idle("reset");
    chk("reset_last", 32'(out_last), 32'h0);
    tick();
    tick();
    reset    = 1'b0;
    in_valid = '0;

    // Single requester 2, three beats
    in_valid = 4'b0100;
    in_data[16 +: 8] = 8'hA1;
    #1;
    chk_idle("single_arb");
    tick();
    #1;
    chk_beat("single_b1", 2'd2, 8'hA1, 1'b0);
    chk("single_b1_ready", 32'(in_ready), 32'h4);
    tick();
    in_data[16 +: 8] = 8'hA2;
    #1;
    chk_beat("single_b2", 2'd2, 8'hA2, 1'b0);
    tick();
    in_data[16 +: 8] = 8'hA3;
    in_last = 4'b0100;
    #1;
    chk_beat("single_b3", 2'd2, 8'hA3, 1'b1);
    tick();
    in_valid = '0;
    in_last  = '0;
    #1;
    chk_idle("single_bubble");

    // Rotation from reset priority, 1-beat bursts
    reset = 1'b1;
    #1;
    reset = 1'b0;
    in_valid = 4'b1111;
    in_last  = 4'b1111;
    in_data  = 32'h13121110;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk_idle("rot_bubble");
      tick();
      #1;
      mask = 4'b0001 << order[k];
      chk_beat("rot", order[k], 8'h10 + 8'(order[k]), 1'b1);
      chk("rot_ready", 32'(in_ready), 32'(mask));
      tick();
    end
    in_valid = '0;
    in_last  = '0;

    // Burst cap: requester 1 six beats, requester 3 interleaves at the cap
    reset = 1'b1;
    #1;
    reset = 1'b0;
    in_valid = 4'b1010;
    in_last  = 4'b1000;
    in_data  = 32'h3300B100;
    #1;
    chk_idle("cap_arb");
    tick();
    #1;
    chk_beat("cap_b1", 2'd1, 8'hB1, 1'b0);
    tick();
    in_data[8 +: 8] = 8'hB2;
    #1;
    chk_beat("cap_b2", 2'd1, 8'hB2, 1'b0);
    tick();
    in_data[8 +: 8] = 8'hB3;
    #1;
    chk_beat("cap_b3", 2'd1, 8'hB3, 1'b0);
    tick();
    in_data[8 +: 8] = 8'hB4;
    #1;
    chk_beat("cap_b4", 2'd1, 8'hB4, 1'b1);
    tick();
    #1;
    chk_idle("cap_bubble1");
    tick();
    #1;
    chk_beat("cap_r3", 2'd3, 8'h33, 1'b1);
    tick();
    #1;
    chk_idle("cap_bubble2");
    tick();
    in_data[8 +: 8] = 8'hB5;
    #1;
    chk_beat("cap_b5", 2'd1, 8'hB5, 1'b0);
    tick();
    in_data[8 +: 8] = 8'hB6;
    in_last = 4'b1010;
    #1;
    chk_beat("cap_b6", 2'd1, 8'hB6, 1'b1);
    tick();
    in_valid = '0;
    in_last  = '0;
    in_data  = '0;

    // Lock and back-pressure: requester 0 bursting, requester 1 waiting
    in_valid = 4'b0011;
    in_data  = 32'h0000D1C1;
    #1;
    chk_idle("lock_arb");
    tick();
    #1;
    chk_beat("lock_c1", 2'd0, 8'hC1, 1'b0);
    chk("lock_c1_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 4'b0010;
    #1;
    chk("lock_gap1_valid", 32'(out_valid), 32'h0);
    chk("lock_gap1_src", 32'(out_source), 32'h0);
    chk("lock_gap1_ready", 32'(in_ready), 32'h1);
    chk("lock_gap1_data", 32'(out_data), 32'h0);
    tick();
    out_ready = 1'b0;
    #1;
    chk("lock_gap2_ready", 32'(in_ready), 32'h0);
    chk("lock_gap2_src", 32'(out_source), 32'h0);
    tick();
    out_ready = 1'b1;
    #1;
    chk("lock_gap3_ready", 32'(in_ready), 32'h1);
    chk("lock_gap3_valid", 32'(out_valid), 32'h0);
    tick();
    in_valid = 4'b0011;
    in_data[0 +: 8] = 8'hC2;
    out_ready = 1'b0;
    #1;
    chk_beat("lock_hold", 2'd0, 8'hC2, 1'b0);
    chk("lock_hold_ready", 32'(in_ready), 32'h0);
    tick();
    out_ready = 1'b1;
    #1;
    chk_beat("lock_c2", 2'd0, 8'hC2, 1'b0);
    tick();
    in_data[0 +: 8] = 8'hC3;
    in_last = 4'b0001;
    #1;
    chk_beat("lock_c3", 2'd0, 8'hC3, 1'b1);
    tick();
    in_valid = '0;
    in_last  = '0;
    in_data  = '0;
    #1;
    chk_idle("lock_done");

    // Wrap priority: make requester 3 the last grant, then 0 and 3 compete
    in_valid = 4'b1000;
    in_last  = 4'b1000;
    in_data  = 32'h33000000;
    tick();
    #1;
    chk_beat("wrap_pre", 2'd3, 8'h33, 1'b1);
    tick();
    in_valid = 4'b1001;
    in_last  = 4'b1001;
    in_data  = 32'h33000044;
    #1;
    chk_idle("wrap_arb");
    tick();
    #1;
    chk_beat("wrap_first", 2'd0, 8'h44, 1'b1);
    tick();
    tick();
    #1;
    chk_beat("wrap_second", 2'd3, 8'h33, 1'b1);
    tick();
    in_valid = '0;
    in_last  = '0;
    in_data  = '0;

    // Reset mid-burst on requester 2
    in_valid = 4'b0100;
    in_data  = 32'h00E10000;
    tick();
    #1;
    chk_beat("rst_e1", 2'd2, 8'hE1, 1'b0);
    tick();
    in_data[16 +: 8] = 8'hE2;
    #1;
    chk_beat("rst_e2", 2'd2, 8'hE2, 1'b0);
    tick();
    in_data[16 +: 8] = 8'hE3;
    #1;
    chk_beat("rst_e3", 2'd2, 8'hE3, 1'b0);
    reset = 1'b1;
    #1;
    chk_idle("rst_async");
    tick();
    reset    = 1'b0;
    in_valid = 4'b0011;
    in_last  = 4'b0011;
    in_data  = 32'h0000F1F0;
    #1;
    chk_idle("rst_release");
    tick();
    #1;
    chk_beat("rst_regrant", 2'd0, 8'hF0, 1'b1);
    tick();
    tick();
    #1;
    chk_beat("rst_next", 2'd1, 8'hF1, 1'b1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
